tdm_mux_4x1: RTL

TDM_MUX_4X1 -- requirements
Module: tdm_mux_4x1

---
 rtl/tdm_mux_pkg.sv | 13 +
 rtl/mux_4x1.sv | 25 ++
 rtl/tdm_mux_4x1.sv | 74 +++++++
 3 files changed

// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the 4-channel TDM serializer: FSM state encoding and
// frame geometry constants.
package tdm_mux_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int unsigned NUM_CH    = 4;
   localparam logic [1:0]  LAST_SLOT = 2'd3;

endpackage

// File: rtl/mux_4x1.sv
// Combinational 4:1 selector of W-bit channels, used to pick the channel
// for the current TDM slot.
module mux_4x1 #(
   parameter int unsigned W = 1
) (
   input  logic [W-1:0] c0,
   input  logic [W-1:0] c1,
   input  logic [W-1:0] c2,
   input  logic [W-1:0] c3,
   input  logic [1:0]   sel,
   output logic [W-1:0] y
);

   always_comb begin
      y = '0;
      unique case (sel)
         2'd0: y = c0;
         2'd1: y = c1;
         2'd2: y = c2;
         2'd3: y = c3;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/tdm_mux_4x1.sv
// Captures a 4-channel frame and serializes it one channel per cycle, with
// back-to-back frames accepted in the last slot without a gap.
module tdm_mux_4x1
   import tdm_mux_pkg::*;
#(
   parameter int unsigned W = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4*W-1:0]     i,
   input  logic               i_valid,
   output logic               i_ready,
   output logic [W-1:0]       y,
   output logic [1:0]         s,
   output logic               y_valid,
   output logic               sof,
   output logic               eof
);

   state_t         state;
   logic [1:0]     slot;
   logic [4*W-1:0] frame;
   logic [W-1:0]   sel_data;
   logic           accept;

   assign i_ready = (state == IDLE) || ((state == SCAN) && (slot == LAST_SLOT));
   assign accept  = i_valid && i_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         slot  <= '0;
         frame <= '0;
      end else if (accept) begin
         // Acceptance in IDLE or at the last slot both restart at slot 0.
         frame <= i;
         state <= SCAN;
         slot  <= '0;
      end else if (state == SCAN) begin
         if (slot == LAST_SLOT) begin
            state <= IDLE;
            slot  <= '0;
         end else begin
            slot  <= slot + 2'd1;
         end
      end
   end

   mux_4x1 #(.W(W)) u_mux (
      .c0  (frame[0*W +: W]),
      .c1  (frame[1*W +: W]),
      .c2  (frame[2*W +: W]),
      .c3  (frame[3*W +: W]),
      .sel (slot),
      .y   (sel_data)
   );

   // Outputs depend only on state/slot/frame registers, never on i or i_valid.
   always_comb begin
      y       = '0;
      s       = '0;
      y_valid = 1'b0;
      sof     = 1'b0;
      eof     = 1'b0;
      if (state == SCAN) begin
         y       = sel_data;
         s       = slot;
         y_valid = 1'b1;
         sof     = (slot == 2'd0);
         eof     = (slot == LAST_SLOT);
      end
   end

endmodule
